// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and sizing for the round-robin RAM port arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam int unsigned MAX_NUM_REQ = 4;
    // Requester ids are carried at the width needed for the largest legal NUM_REQ.
    localparam int unsigned ID_WIDTH    = $clog2(MAX_NUM_REQ);

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester handshake and RAM control signals for ram_port_arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_cs;
    logic                          mem_we;
    logic                          mem_oe;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  ack, rdata, mem_addr, mem_cs, mem_we, mem_oe
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output ack, rdata, mem_addr, mem_cs, mem_we, mem_oe
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts just after the pointer, skipping masked requesters.
module ram_port_arbiter_rr_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]        i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    input  logic [N-1:0]        i_excl,
    output logic [N-1:0]        o_grant,
    output logic [ID_WIDTH-1:0] o_id,
    output logic                o_any
);

    localparam int NI = int'(N);

    logic [N-1:0] w_req;

    assign w_req = i_req & ~i_excl;

    // Distance k = 1..N from the pointer; constant indices keep the loop unrolled cleanly.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= NI; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (!o_any && w_req[i] && (((int'(i_ptr) + k) % NI) == i)) begin
                    o_any      = 1'b1;
                    o_grant[i] = 1'b1;
                    o_id       = ID_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM among NUM_REQ req/ack requesters with round-robin arbitration.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_port_arbiter_if.slave    bus,
    inout  wire [DATA_WIDTH-1:0] mem_data
);

    state_e                r_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_ack;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_cs;
    logic                  r_mem_we;
    logic                  r_mem_oe;

    logic [NUM_REQ-1:0]    w_excl;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_WIDTH-1:0]   w_id;
    logic                  w_any;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // The just-served requester still holds req during RESP, so it is masked out.
    assign w_excl = (r_state == RESP) ? r_gnt : '0;

    ram_port_arbiter_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .i_excl  (w_excl),
        .o_grant (w_gnt),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_gnt[i]) begin
                w_sel_we    = bus.req_we[i];
                w_sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_ptr      <= ID_WIDTH'(NUM_REQ - 1);
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_oe   <= 1'b0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                IDLE, RESP: begin
                    if (w_any) begin
                        r_state    <= ACCESS;
                        r_gnt      <= w_gnt;
                        r_ptr      <= w_id;
                        r_mem_addr <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_mem_cs   <= 1'b1;
                        r_mem_we   <= w_sel_we;
                        r_mem_oe   <= !w_sel_we;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    // RAM has been driving the bus since the mid-cycle negedge.
                    if (r_mem_oe) begin
                        r_rdata <= mem_data;
                    end
                    r_ack    <= r_gnt;
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_mem_oe <= 1'b0;
                    r_state  <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_cs   = r_mem_cs;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_oe   = r_mem_oe;
    assign mem_data     = r_mem_we ? r_wdata : 'z;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, reset/latch corner cases and random
// two-requester traffic checked against a transaction-level round-robin model.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NR = 2;

    typedef struct {
        int id;
        bit we;
        int addr;
        int wdata;
        int exp_rdata;
        int lat;
    } vec_t;

    typedef struct {
        bit we;
        int addr;
        int wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
    wire [DW-1:0] mem_data;

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_data (mem_data)
    );

    // RAM model: posedge write, negedge read capture, drives the bus while cs & oe & !we.
    logic [DW-1:0] ram [4096];
    logic [DW-1:0] ram_q;
    assign mem_data = (bus.mem_cs && bus.mem_oe && !bus.mem_we) ? ram_q : 'z;
    always @(negedge clk) if (bus.mem_cs && bus.mem_oe && !bus.mem_we) ram_q <= ram[bus.mem_addr];
    always @(posedge clk) if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] <= mem_data;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_mem [4096];
    logic [DW-1:0] rd_hold;
    int            last_served;
    txn_t          q0[$];
    txn_t          q1[$];
    vec_t          vecs[12];
    int            addrs[6] = '{'h010, 'h020, 'hFFF, 'h000, 'h7FF, 'h800};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic present(input int id, input txn_t t);
        bus.req_we[id]               = t.we;
        bus.req_addr[id*AW +: AW]    = AW'(t.addr);
        bus.req_wdata[id*DW +: DW]   = DW'(t.wdata);
        bus.req[id]                  = 1'b1;
    endtask

    // Bus invariants sampled mid-cycle for every scenario.
    logic [NR-1:0] prev_ack = '0;
    always @(negedge clk) begin
        if (!rst) begin
            check("oe_we_exclusive", 32'(bus.mem_oe && bus.mem_we), 0);
            check("ack_onehot", 32'($onehot0(bus.ack)), 1);
            check("ack_single_cycle", 32'(|(bus.ack & prev_ack)), 0);
            prev_ack = bus.ack;
        end
    end

    task automatic run_row(input int r, input vec_t v);
        int n = 0;
        bit got = 1'b0;
        int wr = 0;
        int rd = 0;
        int bad = 0;
        present(v.id, '{we: v.we, addr: v.addr, wdata: v.wdata});
        while (!got && n < 12) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_cs) begin
                if (bus.mem_we) begin
                    wr++;
                    if (32'(mem_data) != v.wdata) bad++;
                end
                if (bus.mem_oe) rd++;
                if (32'(bus.mem_addr) != v.addr) bad++;
            end
            got = (bus.ack[v.id] == 1'b1);
        end
        bus.req[v.id] = 1'b0;
        check($sformatf("row%0d_latency", r), n, v.lat);
        check($sformatf("row%0d_ack", r), 32'(bus.ack), 32'(1 << v.id));
        check($sformatf("row%0d_rdata", r), 32'(bus.rdata), v.exp_rdata);
        check($sformatf("row%0d_wr_cycles", r), wr, v.we ? 1 : 0);
        check($sformatf("row%0d_rd_cycles", r), rd, v.we ? 0 : 1);
        check($sformatf("row%0d_addr_data", r), bad, 0);
        if (v.we) model_mem[v.addr] = DW'(v.wdata);
        rd_hold     = DW'(v.exp_rdata);
        last_served = v.id;
    endtask

    // Both requesters present their queues back to back; the model predicts who is served,
    // the spacing between acks and the returned data.
    task automatic run_dual(input string tag);
        int   n[2];
        int   s[2];
        int   prev = -1;
        int   cyc = 0;
        int   last_cyc = 0;
        int   exp_id;
        txn_t t;
        n[0] = q0.size();
        n[1] = q1.size();
        s[0] = 0;
        s[1] = 0;
        if (n[0] > 0) present(0, q0[0]);
        if (n[1] > 0) present(1, q1[0]);
        while ((s[0] < n[0] || s[1] < n[1]) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack != '0) begin
                if (s[0] < n[0] && s[1] < n[1]) exp_id = (last_served + 1) % NR;
                else exp_id = (s[0] < n[0]) ? 0 : 1;
                check({tag, "_grant"}, 32'(bus.ack), 32'(1 << exp_id));
                check({tag, "_ack_spacing"}, cyc - last_cyc, (prev == exp_id) ? 3 : 2);
                t = (exp_id == 0) ? q0[s[0]] : q1[s[1]];
                if (t.we) model_mem[t.addr] = DW'(t.wdata);
                else rd_hold = model_mem[t.addr];
                check({tag, "_rdata"}, 32'(bus.rdata), 32'(rd_hold));
                prev        = exp_id;
                last_served = exp_id;
                last_cyc    = cyc;
                s[exp_id]++;
                if (s[exp_id] < n[exp_id]) present(exp_id, (exp_id == 0) ? q0[s[0]] : q1[s[1]]);
                else bus.req[exp_id] = 1'b0;
            end
        end
        check({tag, "_all_served"}, s[0] + s[1], n[0] + n[1]);
        bus.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        txn_t t;

        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        //          id we  addr    wdata  rdata  lat
        vecs[0]  = '{0, 1, 'h010, 'hA5, 'h00, 2};
        vecs[1]  = '{0, 0, 'h010, 'h00, 'hA5, 3};
        vecs[2]  = '{1, 1, 'hFFF, 'h11, 'hA5, 2};
        vecs[3]  = '{1, 1, 'h000, 'h22, 'hA5, 3};
        vecs[4]  = '{1, 1, 'h7FF, 'h33, 'hA5, 3};
        vecs[5]  = '{1, 1, 'h800, 'h44, 'hA5, 3};
        vecs[6]  = '{1, 0, 'hFFF, 'h00, 'h11, 3};
        vecs[7]  = '{1, 0, 'h000, 'h00, 'h22, 3};
        vecs[8]  = '{1, 0, 'h7FF, 'h00, 'h33, 3};
        vecs[9]  = '{1, 0, 'h800, 'h00, 'h44, 3};
        vecs[10] = '{0, 1, 'h010, 'hC3, 'h44, 2};
        vecs[11] = '{0, 1, 'h020, 'h5A, 'h44, 3};

        #12;
        check("reset_ack", 32'(bus.ack), 0);
        check("reset_rdata", 32'(bus.rdata), 0);
        check("reset_cs_we_oe", 32'({bus.mem_cs, bus.mem_we, bus.mem_oe}), 0);
        check("reset_addr", 32'(bus.mem_addr), 0);
        #11 rst = 1'b0;
        last_served = NR - 1;
        rd_hold     = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 12; r++) run_row(r, vecs[r]);

        // Reset in the middle of a write ACCESS to 0x020 (holds 0x5A).
        present(0, '{we: 1'b1, addr: 'h020, wdata: 'hEE});
        n = 0;
        while (!bus.mem_cs && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        #2;
        check("rst_pre_cs", 32'(bus.mem_cs), 1);
        rst = 1'b1;
        #1;
        check("rst_cs_drop", 32'(bus.mem_cs), 0);
        check("rst_we_oe", 32'({bus.mem_we, bus.mem_oe}), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        check("rst_addr", 32'(bus.mem_addr), 0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_intact", 32'(ram[12'h020]), 'h5A);
        check("rst_no_ack", 32'(bus.ack), 0);
        rst         = 1'b0;
        last_served = NR - 1;
        rd_hold     = '0;
        @(posedge clk); #1;

        // Both rise together: 0 first after reset, then alternation with RESP->ACCESS.
        q0.delete();
        q1.delete();
        q0.push_back('{we: 1'b0, addr: 'h020, wdata: 0});
        q0.push_back('{we: 1'b0, addr: 'h010, wdata: 0});
        q1.push_back('{we: 1'b0, addr: 'hFFF, wdata: 0});
        q1.push_back('{we: 1'b0, addr: 'h000, wdata: 0});
        run_dual("dual_read");
        repeat (3) @(posedge clk);
        #1;

        // Inputs changed after the accept edge must not affect the latched access.
        present(0, '{we: 1'b0, addr: 'h010, wdata: 0});
        @(posedge clk); #1;
        check("latch_accept_cs", 32'(bus.mem_cs), 1);
        check("latch_accept_addr", 32'(bus.mem_addr), 'h010);
        bus.req_addr[AW-1:0]  = 12'h800;
        bus.req_we[0]         = 1'b1;
        bus.req_wdata[DW-1:0] = 8'h99;
        n = 0;
        while (bus.ack[0] !== 1'b1 && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        check("latch_ack_latency", n, 1);
        check("latch_rdata", 32'(bus.rdata), 'hC3);
        bus.req[0]    = 1'b0;
        bus.req_we[0] = 1'b0;
        rd_hold       = 8'hC3;
        last_served   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("latch_ram_800", 32'(ram[12'h800]), 'h44);

        for (int round = 0; round < 4; round++) begin
            q0.delete();
            q1.delete();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                t.we    = ($urandom_range(0, 1) == 1);
                t.addr  = addrs[$urandom_range(0, 5)];
                t.wdata = int'($urandom_range(0, 255));
                q0.push_back(t);
            end
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                t.we    = ($urandom_range(0, 1) == 1);
                t.addr  = addrs[$urandom_range(0, 5)];
                t.wdata = int'($urandom_range(0, 255));
                q1.push_back(t);
            end
            run_dual($sformatf("rand%0d", round));
            repeat (3) @(posedge clk);
            #1;
        end

        for (int a = 0; a < 6; a++) begin
            check($sformatf("ram_final_%0h", addrs[a]), 32'(ram[addrs[a]]),
                  32'(model_mem[addrs[a]]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
